resp_misr_compactor: RTL and testbench

- Downstream capture stage for the generated combinational benchmark netlists (25-in / 11-out class).
- Consumes one output vector (f1..fN) per handshake and folds it into a multiple-input signature register (MISR).
- Counts accepted vectors; after N_PATTERNS vectors, compares the signature with a golden value and reports pass/fail.
- Used in the dataset flow to fingerprint each synthesised variant (RESYN2 etc.) against its source circuit.

---
 rtl/resp_misr_compactor.sv | 65 ++++++
 tb/tb_resp_misr_compactor.sv | 137 +++++++++++++
 2 files changed

// File: rtl/resp_misr_compactor.sv
// resp_misr_compactor: MISR response compactor with pattern counter and golden compare.
// Defining MISR_XMASK_EN adds resp_xmask; masked response bits are zeroed before folding.
module resp_misr_compactor #(
    parameter int              OUT_W      = 11,
    parameter int              SIG_W      = 16,
    parameter logic [SIG_W-1:0] POLY      = 16'h1021,
    parameter logic [SIG_W-1:0] SEED      = 16'hFFFF,
    parameter int              N_PATTERNS = 1024,
    parameter logic [SIG_W-1:0] GOLDEN    = 16'h0000,
    parameter int              CNT_W      = $clog2(N_PATTERNS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             resp_valid,
    input  logic [OUT_W-1:0] resp_data,
`ifdef MISR_XMASK_EN
    input  logic [OUT_W-1:0] resp_xmask,
`endif
    output logic             resp_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [SIG_W-1:0] signature,
    output logic [CNT_W-1:0] count
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_next;
    logic accept, last, load;
    logic [OUT_W-1:0] data_used;
    logic [SIG_W-1:0] sig_next;
`ifdef MISR_XMASK_EN
    assign data_used = resp_data & ~resp_xmask;
`else
    assign data_used = resp_data;
`endif
    assign accept = resp_valid && resp_ready;
    assign last = accept && (count == CNT_W'(N_PATTERNS - 1));
    assign load = (state != RUN) && start;
    assign sig_next = {signature[SIG_W-2:0], 1'b0} ^ (signature[SIG_W-1] ? POLY : '0) ^ SIG_W'(data_used);
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_next;
    end
    always_comb begin
        state_next = (state == RUN) ? (last ? DONE : RUN) : (start ? RUN : state);
    end
    // Handshake and status are pure state decodes, so resp_ready never depends on resp_valid.
    always_comb begin
        resp_ready = (state == RUN);
        busy = (state == RUN);
        done = (state == DONE);
    end
    always_ff @(posedge clk) begin
        if (rst || load) begin
            signature <= SEED;
            count <= '0;
            pass <= 1'b0;
        end else if (accept) begin
            signature <= sig_next;
            count <= count + CNT_W'(1);
            if (last) pass <= (sig_next == GOLDEN);
        end
    end
endmodule

// File: tb/tb_resp_misr_compactor.sv
// tb_resp_misr_compactor: randomized scoreboard bench against a polynomial-arithmetic reference model.
module tb_resp_misr_compactor;
    localparam int NP = 3;
    localparam logic [15:0] SEED = 16'hFFFF;
    localparam logic [15:0] GOLD = 16'h90E3;
`ifdef MISR_XMASK_EN
    localparam bit XM = 1'b1;
`else
    localparam bit XM = 1'b0;
`endif
    logic clk = 0, rst = 1, start = 0, resp_valid = 0;
    logic [10:0] resp_data = '0, mask = '0;
    logic resp_ready, busy, done, pass;
    logic [15:0] signature;
    logic [1:0] count;
    int checks = 0, errors = 0;
    typedef struct {logic [15:0] sig; int cnt;} exp_t;
    exp_t q[$];
    logic [15:0] m_sig = SEED;
    int m_cnt = 0;
    bit m_run = 0, m_done = 0, m_pass = 0;

    resp_misr_compactor #(.OUT_W(11), .SIG_W(16), .POLY(16'h1021), .SEED(SEED),
                          .N_PATTERNS(NP), .GOLDEN(GOLD)) dut (
        .clk(clk), .rst(rst), .start(start), .resp_valid(resp_valid), .resp_data(resp_data),
`ifdef MISR_XMASK_EN
        .resp_xmask(mask),
`endif
        .resp_ready(resp_ready), .busy(busy), .done(done), .pass(pass),
        .signature(signature), .count(count));

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Signature times x modulo the feedback polynomial, plus the response as a low-order term.
    function automatic logic [15:0] fold(input logic [15:0] s, input logic [10:0] d);
        int v = int'(s) * 2;
        if (v >= 65536) v = (v - 65536) ^ 32'h1021;
        return 16'(v) ^ {5'b0, d};
    endfunction

    task automatic cyc(input bit r, input bit s, input bit v, input logic [10:0] d, input logic [10:0] m);
        @(negedge clk);
        rst = r; start = s; resp_valid = v; resp_data = d; mask = m;
        if (r) begin
            m_run = 0; m_done = 0; m_sig = SEED; m_cnt = 0; m_pass = 0;
        end else if (m_run && v) begin
            m_sig = fold(m_sig, d & ~(XM ? m : 11'h0));
            m_cnt++;
            q.push_back('{m_sig, m_cnt});
            if (m_cnt == NP) begin
                m_run = 0; m_done = 1; m_pass = (m_sig == GOLD);
            end
        end else if (!m_run && s) begin
            m_run = 1; m_done = 0; m_sig = SEED; m_cnt = 0; m_pass = 0;
        end
        @(posedge clk);
        #1;
        check("resp_ready", 32'(resp_ready), 32'(m_run));
        check("busy", 32'(busy), 32'(m_run));
        check("done", 32'(done), 32'(m_done));
        check("signature", 32'(signature), 32'(m_sig));
        check("count", 32'(count), 32'(m_cnt));
        if (m_done) check("pass", 32'(pass), 32'(m_pass));
    endtask

    // Monitor: every handshake the DUT takes must match the next queued model result.
    always @(posedge clk) begin
        bit hs;
        hs = resp_valid && resp_ready && !rst;
        #2;
        if (hs) begin
            if (q.size() == 0) check("sb_unexpected_accept", 32'(1), 32'(0));
            else begin
                exp_t e;
                e = q.pop_front();
                check("sb_signature", 32'(signature), 32'(e.sig));
                check("sb_count", 32'(count), 32'(e.cnt));
            end
        end
    end

    initial begin
        cyc(1, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0);
        for (int i = 0; i < 5; i++) cyc(0, 0, 1, 11'h555, 0);
        check("idle_ready", 32'(resp_ready), 32'(0));
        check("idle_sig", 32'(signature), 32'hFFFF);
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 11'h7FF, 0);
        check("first_7ff", 32'(signature), 32'hE820);
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check("golden_done", 32'(done), 32'(1));
        check("golden_pass", 32'(pass), 32'(1));
        cyc(0, 0, 1, 11'h123, 0);
        check("done_hold_sig", 32'(signature), 32'h90E3);
        cyc(0, 1, 0, 0, 0);
        check("restart_done_clr", 32'(done), 32'(0));
        cyc(0, 0, 1, 0, 0);
        check("first_000", 32'(signature), 32'hEFDF);
        cyc(0, 1, 0, 11'h3FF, 0);
        cyc(0, 0, 1, 11'h001, 0);
        cyc(0, 1, 1, 11'h002, 0);
        check("toggle_done", 32'(done), 32'(1));
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 11'h0F0, 0);
        cyc(0, 1, 1, 11'h00F, 0);
        check("start_ignored", 32'(count), 32'(2));
        cyc(1, 1, 1, 11'h7FF, 0);
        check("rst_sig", 32'(signature), 32'hFFFF);
        check("rst_count", 32'(count), 32'(0));
        check("rst_idle", 32'(busy), 32'(0));
`ifdef MISR_XMASK_EN
        cyc(0, 1, 0, 0, 0);
        cyc(0, 0, 1, 11'h7FF, 11'h7FF);
        check("xmask_all", 32'(signature), 32'hEFDF);
`endif
        for (int n = 0; n < 40; n++) begin
            cyc(0, 1, 0, 0, 0);
            for (int k = 0; k < 8; k++)
                cyc(($urandom_range(0, 40) == 0), ($urandom_range(0, 3) == 0), $urandom_range(0, 1) == 1,
                    11'($urandom), 11'($urandom));
        end
        repeat (3) @(posedge clk);
        check("sb_drained", 32'(q.size()), 32'(0));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
